// File: rtl/bus_arbiter_6502.sv
// Memory-port arbiter between the 6502 core and a single DMA requester.
// DMA wins each cycle, but a burst is capped at MAX_DMA_RUN grants before the CPU gets one slot.
module bus_arbiter_6502 #(
  parameter int MAX_DMA_RUN = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  input  logic        ext_rdy,
  output logic        cpu_rdy,
  output logic [7:0]  cpu_rdata,
  input  logic        dma_req,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  input  logic        dma_we,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [7:0]  dma_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata
);

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        we;
  } mem_req_t;

  localparam logic [7:0] RUN_LAST = 8'(MAX_DMA_RUN - 1);

  logic [7:0] run_cnt;
  logic       force_cpu;
  logic       cpu_served_q;
  logic       dma_read_q;
  logic [7:0] cpu_hold;
  mem_req_t   cpu_side, dma_side, mem_side;

  assign dma_gnt = dma_req & ~force_cpu & reset;
  assign cpu_rdy = ext_rdy & ~dma_gnt & reset;

  // A stalled CPU cycle must not write; the core re-presents the same bus next cycle.
  assign cpu_side = '{addr: cpu_addr, wdata: cpu_wdata, we: cpu_we & cpu_rdy};
  assign dma_side = '{addr: dma_addr, wdata: dma_wdata, we: dma_we};

  always_comb begin
    mem_side = cpu_side;
    if (dma_gnt) mem_side = dma_side;
  end

  assign mem_addr  = mem_side.addr;
  assign mem_wdata = mem_side.wdata;
  assign mem_we    = mem_side.we;

  // The counter wraps to 0 on the grant that completes a run, so it reads 0 in the forced slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_cnt   <= '0;
      force_cpu <= 1'b0;
    end else if (dma_gnt) begin
      if (run_cnt == RUN_LAST) begin
        run_cnt   <= '0;
        force_cpu <= 1'b1;
      end else begin
        run_cnt   <= run_cnt + 8'd1;
        force_cpu <= 1'b0;
      end
    end else begin
      run_cnt   <= '0;
      force_cpu <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_served_q <= 1'b0;
      dma_read_q   <= 1'b0;
      cpu_hold     <= 8'h00;
    end else begin
      cpu_served_q <= cpu_rdy & ~cpu_we;
      dma_read_q   <= dma_gnt & ~dma_we;
      if (cpu_served_q) cpu_hold <= mem_rdata;
    end
  end

  // Hold register keeps DI stable for the core while it is stalled.
  assign cpu_rdata  = cpu_served_q ? mem_rdata : cpu_hold;
  assign dma_rvalid = dma_read_q;
  assign dma_rdata  = mem_rdata;

endmodule

// File: tb/tb_bus_arbiter_6502.sv
// Bench for bus_arbiter_6502: a cycle model predicts grants and memory strobes,
// read returns are pushed to queues at issue and popped one cycle later.
module tb_bus_arbiter_6502;
  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cpu_addr = '0, dma_addr = '0, mem_addr;
  logic [7:0]  cpu_wdata = '0, dma_wdata = '0, mem_wdata, cpu_rdata, dma_rdata, mem_rdata;
  logic        cpu_we = 1'b0, dma_we = 1'b0, ext_rdy = 1'b0, dma_req = 1'b0;
  logic        cpu_rdy, dma_gnt, dma_rvalid, mem_we;

  bus_arbiter_6502 #(.MAX_DMA_RUN(MAX)) dut (
    .clk(clk), .reset(rst_n),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .ext_rdy(ext_rdy), .cpu_rdy(cpu_rdy), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_we(dma_we),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    if (a == 16'h1234) return 8'hA5;
    if (a == 16'h8000) return 8'h3C;
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Synchronous RAM: data valid the cycle after its address.
  logic [7:0] ram [0:65535];
  initial for (int i = 0; i < 65536; i++) ram[i] = init_byte(16'(i));
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [7:0] m_ram [logic [15:0]];
  int         m_run = 0;
  logic       m_force = 1'b0;
  logic [7:0] m_hold = 8'h00;
  logic [7:0] cpu_q[$];
  logic [7:0] dma_q[$];

  function automatic logic [7:0] m_rd(input logic [15:0] a);
    return m_ram.exists(a) ? m_ram[a] : init_byte(a);
  endfunction

  task automatic cyc(input logic rst, input logic erdy,
                     input logic [15:0] ca, input logic [7:0] cw, input logic cwe,
                     input logic dr, input logic [15:0] da, input logic [7:0] dw, input logic dwe);
    logic eg, er, ewe;
    logic [7:0] d;
    @(posedge clk); #1;
    rst_n = rst; ext_rdy = erdy;
    cpu_addr = ca; cpu_wdata = cw; cpu_we = cwe;
    dma_req = dr; dma_addr = da; dma_wdata = dw; dma_we = dwe;
    if (!rst) begin
      m_run = 0; m_force = 1'b0; m_hold = 8'h00;
      cpu_q.delete(); dma_q.delete();
    end
    @(negedge clk);
    // Read returns issued last cycle
    if (cpu_q.size() > 0) begin
      d = cpu_q.pop_front();
      m_hold = d;
      chk("cpu_rdata_ret", 16'(cpu_rdata), 16'(d));
    end else chk("cpu_rdata_hold", 16'(cpu_rdata), 16'(m_hold));
    if (dma_q.size() > 0) begin
      d = dma_q.pop_front();
      chk("dma_rvalid", 16'(dma_rvalid), 16'd1);
      chk("dma_rdata", 16'(dma_rdata), 16'(d));
    end else chk("dma_rvalid_idle", 16'(dma_rvalid), 16'd0);
    // Grant and memory mux
    eg  = dr & ~m_force & rst;
    er  = erdy & ~eg & rst;
    ewe = eg ? dwe : (cwe & er);
    chk("dma_gnt", 16'(dma_gnt), 16'(eg));
    chk("cpu_rdy", 16'(cpu_rdy), 16'(er));
    chk("mem_we", 16'(mem_we), 16'(ewe));
    if (rst) begin
      chk("mem_addr", mem_addr, eg ? da : ca);
      if (ewe) chk("mem_wdata", 16'(mem_wdata), 16'(eg ? dw : cw));
    end
    if (er && !cwe) cpu_q.push_back(m_rd(ca));
    if (eg && !dwe) dma_q.push_back(m_rd(da));
    if (ewe) m_ram[eg ? da : ca] = eg ? dw : cw;
    if (eg) begin
      m_run++;
      if (m_run == MAX) begin m_force = 1'b1; m_run = 0; end
    end else begin
      m_force = 1'b0; m_run = 0;
    end
  endtask

  logic pend;
  logic [3:0] pat;

  initial begin
    // Reset state
    repeat (2) cyc(0, 1, 16'h1234, 8'h00, 0, 1, 16'h4000, 8'h00, 0);
    // CPU reads, no DMA
    repeat (3) cyc(1, 1, 16'h1234, 8'h00, 0, 0, 16'h0000, 8'h00, 0);
    // Stall with a write pending: no strobe, data held
    repeat (3) cyc(1, 0, 16'h0200, 8'h77, 1, 0, 16'h0000, 8'h00, 0);
    // Continuous DMA: 1111 0 1111 0 pattern, CPU reads on forced slots
    for (int i = 0; i < 10; i++)
      cyc(1, 1, 16'h0010 + 16'(i), 8'h00, 0, 1, 16'h8100 + 16'(i), 8'h00, 0);
    cyc(1, 1, 16'h1234, 8'h00, 0, 0, 16'h0000, 8'h00, 0);
    // CPU write while DMA writes; CPU write lands next cycle, then read back
    cyc(1, 1, 16'h0200, 8'h5A, 1, 1, 16'h0300, 8'hC3, 1);
    cyc(1, 1, 16'h0200, 8'h5A, 1, 0, 16'h0000, 8'h00, 0);
    cyc(1, 1, 16'h0200, 8'h00, 0, 0, 16'h0000, 8'h00, 0);
    cyc(1, 1, 16'h0300, 8'h00, 0, 0, 16'h0000, 8'h00, 0);
    // DMA read of 0x8000; CPU hold value must survive
    cyc(1, 1, 16'h1234, 8'h00, 0, 1, 16'h8000, 8'h00, 0);
    cyc(1, 0, 16'h1234, 8'h00, 0, 0, 16'h0000, 8'h00, 0);
    cyc(1, 0, 16'h1234, 8'h00, 0, 0, 16'h0000, 8'h00, 0);
    // ext_rdy=0 with DMA still counts toward the run; forced slot taken even if stalled
    for (int i = 0; i < 6; i++)
      cyc(1, 0, 16'h0400, 8'h11, 1, 1, 16'h8200 + 16'(i), 8'h00, 0);
    // Reset mid-burst after two grants, held 3 cycles
    cyc(1, 1, 16'h1234, 8'h00, 0, 0, 16'h0000, 8'h00, 0);
    repeat (2) cyc(1, 1, 16'h1234, 8'h00, 0, 1, 16'h8000, 8'h00, 0);
    repeat (3) cyc(0, 1, 16'h1234, 8'h00, 0, 1, 16'h8000, 8'h00, 0);
    for (int i = 0; i < 7; i++)
      cyc(1, 1, 16'h1234, 8'h00, 0, 1, 16'h8300 + 16'(i), 8'h00, 0);
    // Random traffic; DMA keeps its request up until granted
    pend = 1'b0;
    for (int i = 0; i < 200; i++) begin
      logic dr;
      pat = 4'($urandom);
      dr = pend | pat[0] | pat[1];
      cyc(1, pat[2] | pat[3], 16'($urandom_range(16'h0500, 16'h0507)), 8'($urandom), pat[1] & pat[3],
          dr, 16'($urandom_range(16'h0500, 16'h0507)), 8'($urandom), pat[2] & ~pat[0]);
      pend = dr & ~dma_gnt;
    end
    cyc(1, 1, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 0);
    cyc(1, 1, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
